// File: rtl/spectro_wr_addr_gen.sv
// spectro_wr_addr_gen
// Streaming write-address generator for a circular spectrogram history.
// It takes FFT bins from a valid/ready stream and keeps the positive-frequency
// half (bins 0..FFT_SIZE/2-1) of each frame. It drives registered one-hot bank
// write strobes, addresses and data, and reports frame status to the reader.
// NO_FFTS frames are striped across NO_BANKS banks. Each bank holds
// FPB = NO_FFTS/NO_BANKS frames, and every frame occupies FFT_SIZE/2 words.
// Optional feature: define SPECWR_DROP_CNT_EN to add the drop_cnt output.
// drop_cnt counts the frames discarded while freeze was high.

module spectro_wr_addr_gen #(
  parameter int DATA_WIDTH    = 16,
  parameter int FFT_SIZE      = 256,
  parameter int NO_FFTS       = 50,
  parameter int NO_BANKS      = 2,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_last,
  input  logic                       freeze,
  input  logic                       clr_err,
  output logic [NO_BANKS-1:0]        wr_en,
  output logic [ADDRESS_WIDTH-1:0]   wr_addr,
  output logic [DATA_WIDTH-1:0]      wr_data,
  output logic [$clog2(NO_FFTS)-1:0] latest_fft,
  output logic                       frame_done,
  output logic                       wrap,
  output logic                       err_sticky
`ifdef SPECWR_DROP_CNT_EN
  ,
  output logic [15:0]                drop_cnt
`endif
);

  localparam int HALF = FFT_SIZE / 2;
  localparam int FPB  = NO_FFTS / NO_BANKS;
  localparam int CW   = $clog2(FFT_SIZE);
  localparam int FW   = $clog2(NO_FFTS);
  localparam int SW   = (FPB > 1) ? $clog2(FPB) : 1;
  localparam int BW   = (NO_BANKS > 1) ? $clog2(NO_BANKS) : 1;

  localparam logic [CW-1:0]            BIN_LAST      = CW'(FFT_SIZE - 1);
  localparam logic [CW-1:0]            BIN_HALF_LAST = CW'(HALF - 1);
  localparam logic [SW-1:0]            SLOT_LAST     = SW'(FPB - 1);
  localparam logic [FW-1:0]            FFT_LAST      = FW'(NO_FFTS - 1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_STEP     = ADDRESS_WIDTH'(HALF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_SKIP  = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic                       r_in_ready;
  logic [CW-1:0]              r_bin_cnt;
  logic [CW-1:0]              w_bin_nxt;
  logic [SW-1:0]              r_slot;
  logic [BW-1:0]              r_bank;
  logic [FW-1:0]              r_fft_idx;
  logic [ADDRESS_WIDTH-1:0]   r_base;
  logic [NO_BANKS-1:0]        r_wr_en;
  logic [ADDRESS_WIDTH-1:0]   r_wr_addr;
  logic [DATA_WIDTH-1:0]      r_wr_data;
  logic [FW-1:0]              r_latest;
  logic                       r_frame_done;
  logic                       r_wrap;
  logic                       r_err;
  logic                       w_accept;
  logic                       w_is_last;
  logic                       w_bad_frame;
  logic                       w_write;
  logic                       w_end_store;
  logic                       w_end_drop;
  logic                       w_err;
  logic [ADDRESS_WIDTH-1:0]   w_addr;

  // One-hot strobe for the bank currently being filled.
  function automatic logic [NO_BANKS-1:0] bank_onehot(input logic [BW-1:0] bank);
    logic [NO_BANKS-1:0] oh;
    oh = {NO_BANKS{1'b0}};
    for (int i = 0; i < NO_BANKS; i++) begin
      oh[i] = (bank == BW'(i));
    end
    return oh;
  endfunction

  assign w_accept    = in_valid & r_in_ready;
  // A frame ends on an explicit in_last, or implicitly when the final bin index arrives without one.
  assign w_is_last   = in_last | (r_bin_cnt == BIN_LAST);
  assign w_bad_frame = in_last ^ (r_bin_cnt == BIN_LAST);
  assign w_addr      = r_base + ADDRESS_WIDTH'(r_bin_cnt);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, bin counter and per-bin write/frame-end decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_bin_nxt   = r_bin_cnt;
    w_write     = 1'b0;
    w_end_store = 1'b0;
    w_end_drop  = 1'b0;
    if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (freeze) begin
            if (w_is_last) begin
              w_end_drop  = 1'b1;
              w_state_nxt = ST_IDLE;
              w_bin_nxt   = {CW{1'b0}};
            end else begin
              w_state_nxt = ST_DROP;
              w_bin_nxt   = r_bin_cnt + CW'(1);
            end
          end else begin
            w_write = 1'b1;
            if (w_is_last) begin
              w_end_store = 1'b1;
              w_state_nxt = ST_IDLE;
              w_bin_nxt   = {CW{1'b0}};
            end else begin
              w_state_nxt = (r_bin_cnt == BIN_HALF_LAST) ? ST_SKIP : ST_WRITE;
              w_bin_nxt   = r_bin_cnt + CW'(1);
            end
          end
        end
        ST_WRITE: begin
          w_write = 1'b1;
          if (w_is_last) begin
            w_end_store = 1'b1;
            w_state_nxt = ST_IDLE;
            w_bin_nxt   = {CW{1'b0}};
          end else begin
            w_state_nxt = (r_bin_cnt == BIN_HALF_LAST) ? ST_SKIP : ST_WRITE;
            w_bin_nxt   = r_bin_cnt + CW'(1);
          end
        end
        ST_SKIP: begin
          if (w_is_last) begin
            w_end_store = 1'b1;
            w_state_nxt = ST_IDLE;
            w_bin_nxt   = {CW{1'b0}};
          end else begin
            w_bin_nxt   = r_bin_cnt + CW'(1);
          end
        end
        ST_DROP: begin
          if (w_is_last) begin
            w_end_drop  = 1'b1;
            w_state_nxt = ST_IDLE;
            w_bin_nxt   = {CW{1'b0}};
          end else begin
            w_bin_nxt   = r_bin_cnt + CW'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_bin_nxt   = {CW{1'b0}};
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
    w_err = (w_end_store | w_end_drop) & w_bad_frame;
  end

  // Ready is low only while reset is applied; the block never back-pressures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready <= 1'b0;
      r_bin_cnt  <= {CW{1'b0}};
    end else begin
      r_in_ready <= 1'b1;
      r_bin_cnt  <= w_bin_nxt;
    end
  end

  // Registered bank write port: one cycle after the accepting handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= {NO_BANKS{1'b0}};
      r_wr_addr <= {ADDRESS_WIDTH{1'b0}};
      r_wr_data <= {DATA_WIDTH{1'b0}};
    end else if (w_write) begin
      r_wr_en   <= bank_onehot(r_bank);
      r_wr_addr <= w_addr;
      r_wr_data <= in_data;
    end else begin
      r_wr_en   <= {NO_BANKS{1'b0}};
    end
  end

  // Frame bookkeeping: advance slot/bank/frame index and the running address base.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fft_idx    <= {FW{1'b0}};
      r_slot       <= {SW{1'b0}};
      r_bank       <= {BW{1'b0}};
      r_base       <= {ADDRESS_WIDTH{1'b0}};
      r_latest     <= {FW{1'b0}};
      r_frame_done <= 1'b0;
      r_wrap       <= 1'b0;
    end else begin
      r_frame_done <= w_end_store;
      r_wrap       <= w_end_store & (r_fft_idx == FFT_LAST);
      if (w_end_store) begin
        r_latest <= r_fft_idx;
        if (r_fft_idx == FFT_LAST) begin
          r_fft_idx <= {FW{1'b0}};
          r_slot    <= {SW{1'b0}};
          r_bank    <= {BW{1'b0}};
          r_base    <= {ADDRESS_WIDTH{1'b0}};
        end else begin
          r_fft_idx <= r_fft_idx + FW'(1);
          if (r_slot == SLOT_LAST) begin
            r_slot <= {SW{1'b0}};
            r_base <= {ADDRESS_WIDTH{1'b0}};
            r_bank <= r_bank + BW'(1);
          end else begin
            r_slot <= r_slot + SW'(1);
            r_base <= r_base + ADDR_STEP;
          end
        end
      end
    end
  end

  // Sticky framing-error flag; a new error outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_err) begin
      r_err <= 1'b1;
    end else if (clr_err) begin
      r_err <= 1'b0;
    end
  end

`ifdef SPECWR_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  // Saturating count of frames discarded while frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= 16'd0;
    end else if (clr_err) begin
      r_drop_cnt <= 16'd0;
    end else if (w_end_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

  assign in_ready   = r_in_ready;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign latest_fft = r_latest;
  assign frame_done = r_frame_done;
  assign wrap       = r_wrap;
  assign err_sticky = r_err;

endmodule

// File: tb/tb_spectro_wr_addr_gen.sv
// Directed testbench for spectro_wr_addr_gen.
// Instance dut uses the default parameters. Instance dut_b uses the small
// 4-bank configuration. Define SPECWR_DROP_CNT_EN to check drop_cnt as well.

module tb_spectro_wr_addr_gen;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        freeze;
  logic        clr_err;
  logic [1:0]  wr_en;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  logic [5:0]  latest_fft;
  logic        frame_done;
  logic        wrap;
  logic        err_sticky;

  logic        b_in_valid;
  logic        b_in_ready;
  logic [15:0] b_in_data;
  logic        b_in_last;
  logic        b_freeze;
  logic        b_clr_err;
  logic [3:0]  b_wr_en;
  logic [5:0]  b_wr_addr;
  logic [15:0] b_wr_data;
  logic [2:0]  b_latest_fft;
  logic        b_frame_done;
  logic        b_wrap;
  logic        b_err_sticky;

`ifdef SPECWR_DROP_CNT_EN
  logic [15:0] drop_cnt;
  logic [15:0] b_drop_cnt;
  int          exp_drop;
`endif

  int   n_checks;
  int   n_errors;
  int   exp_latest;
  logic exp_err;

  spectro_wr_addr_gen dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .freeze(freeze), .clr_err(clr_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .latest_fft(latest_fft),
    .frame_done(frame_done), .wrap(wrap), .err_sticky(err_sticky)
`ifdef SPECWR_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  spectro_wr_addr_gen #(
    .DATA_WIDTH(16), .FFT_SIZE(64), .NO_FFTS(8), .NO_BANKS(4), .ADDRESS_WIDTH(6)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_last(b_in_last), .freeze(b_freeze), .clr_err(b_clr_err),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .latest_fft(b_latest_fft),
    .frame_done(b_frame_done), .wrap(b_wrap), .err_sticky(b_err_sticky)
`ifdef SPECWR_DROP_CNT_EN
    , .drop_cnt(b_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, " in_ready"}, {31'd0, in_ready}, 32'd0);
    check_eq({tag, " wr"}, {2'd0, wr_en, wr_addr, wr_data}, 32'd0);
    check_eq({tag, " status"}, {23'd0, latest_fft, frame_done, wrap, err_sticky}, 32'd0);
    check_eq({tag, " b_wr"}, {6'd0, b_wr_en, b_wr_addr, b_wr_data}, 32'd0);
`ifdef SPECWR_DROP_CNT_EN
    check_eq({tag, " drop_cnt"}, {16'd0, drop_cnt}, 32'd0);
`endif
  endtask

  // Drives one frame into dut and checks each output cycle.
  // gidx counts stored frames since reset. give_last places in_last on bin nbins-1.
  task automatic send_frame(input int gidx, input int nbins, input bit frz, input bit give_last);
    int          ring;
    int          bank;
    int          base;
    bit          is_end;
    bit          bad;
    logic [15:0] d;
    logic [31:0] exp_vec;
    ring = gidx % 50;
    bank = ring / 25;
    base = (ring % 25) * 128;
    for (int b = 0; b < nbins; b++) begin
      d        = 16'(gidx * 37 + b * 5 + 1);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = give_last && (b == nbins - 1);
      freeze   = (b == 0) ? frz : !frz;
      is_end   = in_last || (b == 255);
      bad      = is_end && !(in_last && (b == 255));
      @(posedge clk);
      #1;
      if (!frz && b < 128) begin
        exp_vec = {2'd0, 2'(1 << bank), 12'(base + b), d};
        check_eq($sformatf("wr f%0d b%0d", gidx, b), {2'd0, wr_en, wr_addr, wr_data}, exp_vec);
      end else begin
        check_eq($sformatf("no_wr f%0d b%0d", gidx, b), {30'd0, wr_en}, 32'd0);
      end
      if (is_end) begin
        if (bad) exp_err = 1'b1;
        if (!frz) exp_latest = ring;
`ifdef SPECWR_DROP_CNT_EN
        if (frz) exp_drop++;
        check_eq($sformatf("drop_cnt f%0d", gidx), {16'd0, drop_cnt}, 32'(exp_drop));
`endif
        check_eq($sformatf("end f%0d", gidx), {30'd0, frame_done, wrap},
                 {30'd0, !frz, (!frz && ring == 49)});
        check_eq($sformatf("latest f%0d", gidx), {26'd0, latest_fft}, 32'(exp_latest));
        check_eq($sformatf("err f%0d", gidx), {31'd0, err_sticky}, {31'd0, exp_err});
      end else begin
        check_eq($sformatf("no_end f%0d b%0d", gidx, b), {30'd0, frame_done, wrap}, 32'd0);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    freeze   = 1'b0;
  endtask

  task automatic reset_model();
    exp_latest = 0;
    exp_err    = 1'b0;
`ifdef SPECWR_DROP_CNT_EN
    exp_drop   = 0;
`endif
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    freeze   = 1'b0;
    clr_err  = 1'b0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("in_ready after reset", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic pulse_clr_err();
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    exp_err = 1'b0;
`ifdef SPECWR_DROP_CNT_EN
    exp_drop = 0;
    check_eq("drop_cnt cleared", {16'd0, drop_cnt}, 32'd0);
`endif
    check_eq("err cleared", {31'd0, err_sticky}, 32'd0);
  endtask

  initial begin
    clk        = 1'b0;
    n_checks   = 0;
    n_errors   = 0;
    in_data    = 16'd0;
    b_in_valid = 1'b0;
    b_in_data  = 16'd0;
    b_in_last  = 1'b0;
    b_freeze   = 1'b0;
    b_clr_err  = 1'b0;
    apply_reset();

    // Full history wrap plus the first frame of the next lap.
    for (int g = 0; g <= 50; g++) send_frame(g, 256, 1'b0, 1'b1);

    // Freeze on frame 3, released mid-frame; frame 4 lands in slot 3.
    apply_reset();
    for (int g = 0; g < 3; g++) send_frame(g, 256, 1'b0, 1'b1);
    send_frame(3, 256, 1'b1, 1'b1);
    for (int g = 3; g < 7; g++) send_frame(g, 256, 1'b0, 1'b1);

    // Frame 7: bins 0..59 go in, then reset is applied while bin 60 is on the bus.
    send_frame(7, 60, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    rst_n    = 1'b0;
    #1;
    check_outputs_zero("async reset");
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    send_frame(0, 256, 1'b0, 1'b1);

    // Short frame (in_last on bin 99), then the next frame moves to the next slot.
    send_frame(1, 100, 1'b0, 1'b1);
    send_frame(2, 256, 1'b0, 1'b1);
    pulse_clr_err();
    // No in_last: bin 255 ends the frame implicitly and flags an error.
    send_frame(3, 256, 1'b0, 1'b0);
    send_frame(4, 256, 1'b0, 1'b1);
    pulse_clr_err();

    // Four-bank configuration: two frames per bank, 32 stored bins per frame.
    for (int f = 0; f < 8; f++) begin
      for (int b = 0; b < 64; b++) begin
        b_in_valid = 1'b1;
        b_in_data  = 16'(f * 64 + b + 16'd3);
        b_in_last  = (b == 63);
        @(posedge clk);
        #1;
        if (b < 32) begin
          check_eq($sformatf("b_wr f%0d b%0d", f, b), {6'd0, b_wr_en, b_wr_addr, b_wr_data},
                   {6'd0, 4'(1 << (f / 2)), 6'((f % 2) * 32 + b), b_in_data});
        end else begin
          check_eq($sformatf("b_no_wr f%0d b%0d", f, b), {28'd0, b_wr_en}, 32'd0);
        end
        if (b == 63) begin
          check_eq($sformatf("b_end f%0d", f), {29'd0, b_frame_done, b_wrap, b_err_sticky},
                   {29'd0, 1'b1, (f == 7), 1'b0});
          check_eq($sformatf("b_latest f%0d", f), {29'd0, b_latest_fft}, 32'(f));
        end
      end
    end
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spectro_wr_addr_gen.md
Name: spectro_wr_addr_gen

Overview:
- Streaming successor to the combinational FFT-index-to-RAM mapper.
- Accepts FFT output bins on a valid/ready stream and keeps the positive-frequency half of each frame.
- Generates registered per-bank write enables, addresses and data for a circular spectrogram history of NO_FFTS frames striped across NO_BANKS RAM banks.
- Sits between the FFT core and the spectrogram bank RAMs; provides frame status to the display reader.

Parameters:
- DATA_WIDTH, 16, bin magnitude width.
- FFT_SIZE, 256, bins per input frame (power of 2); only FFT_SIZE/2 are stored.
- NO_FFTS, 50, frames held in history; must be a multiple of NO_BANKS.
- NO_BANKS, 2, number of RAM banks (>=1); FPB = NO_FFTS/NO_BANKS frames per bank.
- ADDRESS_WIDTH, 12, bank address width; must satisfy 2^ADDRESS_WIDTH >= FPB*FFT_SIZE/2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  bin valid.
- in_ready  out  1  bin accepted when in_valid && in_ready.
- in_data  in  DATA_WIDTH  bin magnitude.
- in_last  in  1  marks the final bin of a frame.
- freeze  in  1  when high, new frames are dropped (history is held for readout).
- clr_err  in  1  clears err_sticky.
- wr_en  out  NO_BANKS  one-hot bank write strobe.
- wr_addr  out  ADDRESS_WIDTH  bank write address.
- wr_data  out  DATA_WIDTH  bank write data.
- latest_fft  out  clog2(NO_FFTS)  slot index of the newest completed stored frame.
- frame_done  out  1  one-cycle pulse when a stored frame completes.
- wrap  out  1  one-cycle pulse, coincident with frame_done, when slot NO_FFTS-1 completes.
- err_sticky  out  1  framing error seen.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state IDLE; bin_cnt=0, slot=0, bank=0, fft_idx=0. On assertion mid-frame the partial frame is abandoned and the next accepted bin is treated as bin 0.
- in_ready is held at 1 outside reset; the block never back-pressures the FFT core.
- Counters:
  - bin_cnt: 0..FFT_SIZE-1.
  - slot: 0..FPB-1.
  - bank: 0..NO_BANKS-1.
  - fft_idx: 0..NO_FFTS-1.
  - All counters advance incrementally; no multiplier.
- Address: wr_addr = slot*(FFT_SIZE/2) + bin_cnt, kept as a running base register plus bin_cnt. wr_en = one-hot(bank).
- Latency: one cycle from the accepting handshake to the wr_en/wr_addr/wr_data outputs.
- FSM:
  - IDLE: on the first accepted bin, if freeze=1 -> DROP; else write bin 0 and go to WRITE (or to IDLE if in_last=1 on that bin).
  - WRITE: each accepted bin with bin_cnt < FFT_SIZE/2 is written. At bin_cnt = FFT_SIZE/2-1 go to SKIP, unless in_last is also set.
  - SKIP: bins are accepted and discarded until in_last.
  - DROP: bins are accepted and discarded until in_last; no counters other than bin_cnt advance.
  - freeze is sampled only at frame start; changing it mid-frame has no effect on the current frame.
- Frame end (in_last accepted in WRITE/SKIP/IDLE-write):
  - frame_done pulses and latest_fft <= fft_idx.
  - fft_idx, slot and bank advance. slot wraps at FPB-1, incrementing bank; at fft_idx = NO_FFTS-1 all of fft_idx, slot and bank return to 0 and wrap pulses.
  - These outputs are aligned with the final wr_en of the frame, or one cycle after the last accepted bin if that bin was discarded.
- Framing errors: set err_sticky and return to IDLE with bin_cnt=0.
  - in_last accepted with bin_cnt != FFT_SIZE-1: the frame still counts as completed if it was being stored.
  - bin_cnt reaches FFT_SIZE-1 without in_last: treated as an implicit last.
  - clr_err clears err_sticky; if clr_err and a new error occur in the same cycle, the error wins.
- A short stored frame (in_last before bin FFT_SIZE/2) leaves the unwritten bins of that slot stale; this is not cleared.

Optional Feature:
- Macro SPECWR_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt[15:0], which increments at each frame end taken in DROP state.
  - Saturates at 16'hFFFF; reset to 0; cleared by clr_err.
- Undefined: no port, no counter; DROP behaviour is otherwise identical.

Test Plan:
- Defaults, freeze=0, one 256-bin frame with in_last on bin 255:
  - 128 writes, wr_en=2'b01, addr 0..127, data passed through with 1-cycle latency.
  - Bins 128..255 produce no writes.
  - frame_done=1 and latest_fft=0 after bin 255.
- Frames 0..49 back-to-back:
  - Frame 24 bin 127 -> wr_en=01, addr 3199.
  - Frame 25 bin 0 -> wr_en=10, addr 0.
  - Frame 49 end -> wrap=1, latest_fft=49.
  - Frame 50 bin 0 -> wr_en=01, addr 0.
- freeze=1 at the start of frame 3, deasserted mid-frame:
  - No writes for frame 3; latest_fft stays 2.
  - Frame 4 writes slot 3 (addr base 384).
  - drop_cnt=1 when SPECWR_DROP_CNT_EN is defined.
- in_last on bin 99:
  - err_sticky=1, frame_done=1, bins 0..99 written.
  - The next frame starts at slot+1 addr base.
  - clr_err pulse -> err_sticky=0.
- rst_n low for 2 cycles mid-frame (bin 60 of frame 7):
  - All outputs 0 immediately (async).
  - After release, the next frame writes bank 0 addr 0 and latest_fft=0.
- NO_BANKS=4, NO_FFTS=8, FFT_SIZE=64, ADDRESS_WIDTH=6:
  - Frames 0,1 -> wr_en=0001; frames 2,3 -> 0010; frame 7 bin 31 -> wr_en=1000, addr 63.
